// File: rtl/arbiter_y_div_pkg.sv
// Shared types and default widths for the Arbiter_Y sequential signed divider.
// The remainder output is built only with ARBITER_Y_SDIV_REM_EN defined.
package arbiter_y_div_pkg;

   localparam int DIVIDEND_W_DEF = 32;
   localparam int DIVISOR_W_DEF  = 28;
   localparam int CNT_W_DEF      = $clog2(DIVIDEND_W_DEF + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/arbiter_y_sdiv_32s_28s_seq_if.sv
// Operand/result handshake bundle for the Arbiter_Y divider.
// The remainder signal exists only when ARBITER_Y_SDIV_REM_EN is defined.
interface arbiter_y_sdiv_32s_28s_seq_if #(
   parameter int DIVIDEND_W = 32,
   parameter int DIVISOR_W  = 28
);
   // Both sides use valid/ready: a transfer happens on a rising clk edge with
   // ce high while valid and ready are both high; valid is held until then.
   logic                  in_valid;
   logic                  in_ready;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  out_valid;
   logic                  out_ready;
   logic [DIVIDEND_W-1:0] quotient;
   logic                  div_by_zero;
`ifdef ARBITER_Y_SDIV_REM_EN
   logic [DIVISOR_W-1:0]  remainder;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, div_by_zero, remainder
   );
   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, div_by_zero, remainder
   );
`else
   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, div_by_zero
   );
   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, div_by_zero
   );
`endif
endinterface

// File: rtl/arbiter_y_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module arbiter_y_div_step #(
   parameter int DIVISOR_W = 28
) (
   input  logic [DIVISOR_W:0] rem_i,
   input  logic               bit_i,
   input  logic [DIVISOR_W:0] divisor_i,
   output logic [DIVISOR_W:0] rem_o,
   output logic               q_o
);

   logic [DIVISOR_W+1:0] shifted;
   logic [DIVISOR_W:0]   diff;

   // rem < divisor on entry, so a successful trial difference always fits rem_o
   always_comb begin
      shifted = {rem_i, bit_i};
      q_o     = (shifted >= {1'b0, divisor_i});
      diff    = shifted[DIVISOR_W:0] - divisor_i;
      rem_o   = q_o ? diff : shifted[DIVISOR_W:0];
   end

endmodule

// File: rtl/arbiter_y_sdiv_32s_28s_seq.sv
// Sequential restoring signed divider (32s / 28s), one division in flight.
// Optional remainder output: define ARBITER_Y_SDIV_REM_EN.
module arbiter_y_sdiv_32s_28s_seq
   import arbiter_y_div_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   arbiter_y_sdiv_32s_28s_seq_if.slave bus,
   output div_state_e dbg_state_o
);

   localparam int CNT_W = $clog2(DIVIDEND_W + 1);

   div_state_e            state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DIVIDEND_W-1:0] dvd_q;
   logic [DIVISOR_W:0]    rem_q;
   logic [DIVISOR_W:0]    dvs_q;
   logic                  dvd_neg_q;
   logic                  dvs_neg_q;
   logic [DIVIDEND_W-1:0] quo_q;
   logic                  dbz_q;
`ifdef ARBITER_Y_SDIV_REM_EN
   logic [DIVISOR_W-1:0]  rem_out_q;
`endif

   logic [DIVIDEND_W-1:0] dvd_abs;
   logic [DIVISOR_W-1:0]  dvs_abs;
   logic [DIVISOR_W:0]    step_rem;
   logic                  step_q;

   // Unsigned modular negation: |-2^(W-1)| comes out as 2^(W-1), which is exact.
   assign dvd_abs = bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
   assign dvs_abs = bus.divisor[DIVISOR_W-1]   ? -bus.divisor  : bus.divisor;

   arbiter_y_div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .rem_i     (rem_q),
      .bit_i     (dvd_q[DIVIDEND_W-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         dvd_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
         quo_q     <= '0;
         dbz_q     <= 1'b0;
`ifdef ARBITER_Y_SDIV_REM_EN
         rem_out_q <= '0;
`endif
      end else if (ce) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  dvd_neg_q <= bus.dividend[DIVIDEND_W-1];
                  dvs_neg_q <= bus.divisor[DIVISOR_W-1];
                  dvd_q     <= dvd_abs;
                  dvs_q     <= {1'b0, dvs_abs};
                  rem_q     <= '0;
                  cnt_q     <= CNT_W'(DIVIDEND_W);
                  if (bus.divisor == '0) begin
                     quo_q   <= '1;
                     dbz_q   <= 1'b1;
`ifdef ARBITER_Y_SDIV_REM_EN
                     rem_out_q <= bus.dividend[DIVISOR_W-1:0];
`endif
                     state_q <= ST_DONE;
                  end else begin
                     dbz_q   <= 1'b0;
                     state_q <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               // Quotient bits shift in behind the consumed dividend bits.
               rem_q <= step_rem;
               dvd_q <= {dvd_q[DIVIDEND_W-2:0], step_q};
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               quo_q <= (dvd_neg_q ^ dvs_neg_q) ? -dvd_q : dvd_q;
`ifdef ARBITER_Y_SDIV_REM_EN
               rem_out_q <= dvd_neg_q ? -rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
`endif
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready    = (state_q == ST_IDLE);
   assign bus.out_valid   = (state_q == ST_DONE);
   assign bus.quotient    = quo_q;
   assign bus.div_by_zero = dbz_q;
`ifdef ARBITER_Y_SDIV_REM_EN
   assign bus.remainder   = rem_out_q;
`endif
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_arbiter_y_sdiv_32s_28s_seq.sv
// Directed/scoreboarded bench for the Arbiter_Y sequential signed divider.
module tb_arbiter_y_sdiv_32s_28s_seq;
   import arbiter_y_div_pkg::*;

   logic       clk;
   logic       reset;
   logic       ce;
   div_state_e dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] exp_q[$];
   logic [27:0] exp_rem_q[$];
   logic        exp_dbz_q[$];
   logic [31:0] last_q;

   arbiter_y_sdiv_32s_28s_seq_if bus ();

   arbiter_y_sdiv_32s_28s_seq dut (
      .clk         (clk),
      .reset       (reset),
      .ce          (ce),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pushes the model result, runs one division and compares it at out_valid.
   task automatic run_div(input logic [31:0] a, input logic [27:0] b, input bit rand_ce);
      longint la, lb, lq, lr;
      int     edges;
      int     guard;
      int     exp_edges;
      logic [31:0] eq;
      logic [27:0] er;
      logic        ed;
      la = longint'(signed'(a));
      lb = longint'(signed'(b));
      if (lb == 0) begin
         exp_q.push_back(32'hFFFF_FFFF);
         exp_rem_q.push_back(a[27:0]);
         exp_dbz_q.push_back(1'b1);
         exp_edges = 1;
      end else begin
         lq = la / lb;
         lr = la % lb;
         exp_q.push_back(lq[31:0]);
         exp_rem_q.push_back(lr[27:0]);
         exp_dbz_q.push_back(1'b0);
         exp_edges = 34;
      end
      @(negedge clk);
      ce           = 1'b1;
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      guard = 0;
      while (!bus.out_valid && guard < 2000) begin
         ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk);
         if (ce) edges++;
         @(negedge clk);
         guard++;
      end
      ce = 1'b1;
      chk("done_timeout", 32'(guard < 2000), 32'd1);
      chk("latency_edges", 32'(edges), 32'(exp_edges));
      eq = exp_q.pop_front();
      er = exp_rem_q.pop_front();
      ed = exp_dbz_q.pop_front();
      last_q = eq;
      chk("quotient", bus.quotient, eq);
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(ed));
`ifdef ARBITER_Y_SDIV_REM_EN
      chk("remainder", 32'(bus.remainder), 32'(er));
`else
      er = '0;
`endif
      chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
   endtask

   task automatic release_result();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      reset         = 1'b0;
      ce            = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_quotient", bus.quotient, 32'd0);
      chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifdef ARBITER_Y_SDIV_REM_EN
      chk("rst_remainder", 32'(bus.remainder), 32'd0);
`endif

      run_div(32'd100, 28'd7, 1'b0);
      chk("q_100_7", bus.quotient, 32'd14);
      release_result();
      run_div(-32'sd100, 28'd7, 1'b0);
      release_result();
      run_div(32'd100, -28'sd7, 1'b0);
      release_result();
      run_div(32'h8000_0000, 28'hFFF_FFFF, 1'b0);
      chk("q_min_neg1", bus.quotient, 32'h8000_0000);
      release_result();
      run_div(32'd5, 28'd0, 1'b0);
      chk("q_div0", bus.quotient, 32'hFFFF_FFFF);
      release_result();
      run_div(32'd1000, 28'd3, 1'b1);
      chk("q_1000_3", bus.quotient, 32'd333);

      // Backpressure: result must stay put while out_ready is low.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_quotient", bus.quotient, last_q);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      release_result();

      // Abort a division with reset partway through CALC.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = 32'd50;
      bus.divisor  = 28'd3;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_in_calc", 32'(dbg_state), 32'(ST_CALC));
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_quotient", bus.quotient, 32'd0);
      run_div(32'd9, 28'd2, 1'b0);
      chk("q_9_2", bus.quotient, 32'd4);
      release_result();

      for (int i = 0; i < 6; i++) begin
         run_div(32'($urandom), 28'($urandom), i[0]);
         release_result();
      end
      run_div(-32'sd7, 28'd0, 1'b0);
      release_result();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
